// File: rtl/imul_var_latency.sv
// Iterative 32x32 shift-add multiplier (low 32 bits) with trailing-zero skipping.
// Latency: 1..32 CALC cycles; one operation in flight; result held until ostream_rdy.
module imul_var_latency #(
  parameter int p_max_shift = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        istream_val,
  output logic        istream_rdy,
  input  logic [63:0] istream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy,
  output logic [31:0] ostream_msg
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] result_reg;

  logic [5:0]  skip;
  logic        skip_stop;
  logic [31:0] a_nxt;
  logic [31:0] b_nxt;
  logic [31:0] result_nxt;

  // Only used when b_reg[0] is 0, so bit 0 always counts as one skipped zero.
  always_comb begin
    skip      = 6'd1;
    skip_stop = 1'b0;
    for (int i = 1; i < p_max_shift; i++) begin
      if (!skip_stop && !b_reg[i]) begin
        skip = skip + 6'd1;
      end else begin
        skip_stop = 1'b1;
      end
    end
  end

  always_comb begin
    a_nxt      = a_reg;
    b_nxt      = b_reg;
    result_nxt = result_reg;
    if (b_reg[0]) begin
      result_nxt = result_reg + a_reg;
      a_nxt      = a_reg << 1;
      b_nxt      = b_reg >> 1;
    end else begin
      a_nxt = a_reg << skip;
      b_nxt = b_reg >> skip;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            a_reg      <= istream_msg[63:32];
            b_reg      <= istream_msg[31:0];
            result_reg <= '0;
            state      <= CALC;
          end
        end
        CALC: begin
          if (b_reg == '0) begin
            state <= DONE;
          end else begin
            a_reg      <= a_nxt;
            b_reg      <= b_nxt;
            result_reg <= result_nxt;
            // Finish on the same edge the multiplier is exhausted.
            if (b_nxt == '0) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign istream_rdy = (state == IDLE);
  assign ostream_val = (state == DONE);
  assign ostream_msg = result_reg;

endmodule

// File: tb/tb_imul_var_latency.sv
// Directed bench for imul_var_latency: vector table plus backpressure and reset sequences.
module tb_imul_var_latency;

  logic        clk;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [63:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_msg;

  int total = 0;
  int bad   = 0;

  imul_var_latency #(.p_max_shift(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .istream_msg(istream_msg),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy),
    .ostream_msg(ostream_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          calc;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands on the falling edge; returns just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    istream_val = 1'b1;
    istream_msg = {a, b};
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    istream_msg = {$urandom, $urandom};
  endtask

  // Counts rising edges after the accept edge until ostream_val is seen.
  task automatic wait_result(input logic [31:0] exp_p, input int exp_c, input string name);
    int  n;
    bit  rdy_high;
    n        = 0;
    rdy_high = 1'b0;
    while (!ostream_val && n < 100) begin
      if (istream_rdy) rdy_high = 1'b1;
      istream_msg = {$urandom, $urandom};
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, n, exp_c);
    check({name, " product"}, ostream_msg, exp_p);
    check({name, " rdy low while busy"}, {31'd0, rdy_high}, 32'd0);
  endtask

  task automatic take_result(input string name);
    @(negedge clk);
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
    check({name, " back to idle"}, {30'd0, istream_rdy, ostream_val}, 32'd2);
  endtask

  vec_t vecs[7];

  initial begin
    bit hold_bad;

    vecs[0] = '{32'd6,        32'd7,        32'd42,       3,  "basic"};
    vecs[1] = '{32'h12345678, 32'h0,        32'h0,        1,  "b_zero"};
    vecs[2] = '{32'd3,        32'h80000000, 32'h80000000, 9,  "skip_msb"};
    vecs[3] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 3,  "neg3x5"};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, "all_ones"};
    vecs[5] = '{32'h10,       32'h100,      32'h1000,     3,  "skip8"};
    vecs[6] = '{32'h12345678, 32'h10,       32'h23456780, 2,  "wrap_shift"};

    reset       = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset istream_rdy", {31'd0, istream_rdy}, 32'd1);
    check("reset ostream_val", {31'd0, ostream_val}, 32'd0);
    check("reset ostream_msg", ostream_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle", {30'd0, istream_rdy, ostream_val}, 32'd2);

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(vecs[i].prod, vecs[i].calc, vecs[i].name);
      take_result(vecs[i].name);
    end

    // Backpressure: 11*13 = 143 takes 4 CALC cycles, then hold for 10 cycles.
    start_op(32'd11, 32'd13);
    wait_result(32'd143, 4, "bp");
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!ostream_val || istream_rdy || ostream_msg !== 32'd143) hold_bad = 1'b1;
    end
    check("bp hold stable", {31'd0, hold_bad}, 32'd0);
    @(negedge clk);
    ostream_rdy = 1'b1;
    istream_val = 1'b1;
    istream_msg = {32'd5, 32'd4};
    @(posedge clk);
    #1;
    ostream_rdy = 1'b0;
    check("bp idle after handshake", {30'd0, istream_rdy, ostream_val}, 32'd2);
    @(posedge clk);
    #1;
    check("bp queued accepted", {31'd0, istream_rdy}, 32'd0);
    istream_val = 1'b0;
    wait_result(32'd20, 2, "queued");
    take_result("queued");

    // Reset mid-operation, between clock edges.
    start_op(32'd9, 32'hFF);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset istream_rdy", {31'd0, istream_rdy}, 32'd1);
    check("midreset ostream_val", {31'd0, ostream_val}, 32'd0);
    check("midreset ostream_msg", ostream_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_op(32'd2, 32'd3);
    wait_result(32'd6, 2, "after_reset");
    take_result("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
